// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the fetch state encoding, reset default, NOP word and PC helpers.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Redirect targets are forced onto a word boundary.
    function automatic logic [31:0] pc_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] pc_next_seq(input logic [31:0] addr);
        return addr + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// IF/ID pipeline register plus a one-word buffer that parks a returned
// instruction while the decode stage is stalled.
module fetch_buffer
    import pc_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        use_buf,
    input  logic        capture,
    input  logic        flush,
    input  logic        hold,
    input  logic [31:0] fill_pc,
    input  logic [31:0] fill_instr,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr
);

    logic [31:0] buf_instr;

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_instr   <= NOP;
            if_valid    <= 1'b0;
            if_pc       <= 32'h0000_0000;
            if_pc_plus4 <= 32'h0000_0000;
            if_instr    <= NOP;
        end else begin
            if (flush) begin
                buf_instr <= NOP;
            end else if (capture) begin
                buf_instr <= fill_instr;
            end

            // Flush wins; otherwise a load fills the stage, a hold keeps it,
            // and anything else leaves a bubble.
            if (flush) begin
                if_valid <= 1'b0;
            end else if (load) begin
                if_valid    <= 1'b1;
                if_pc       <= fill_pc;
                if_pc_plus4 <= pc_next_seq(fill_pc);
                if_instr    <= use_buf ? buf_instr : fill_instr;
            end else if (!hold) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch: one outstanding memory request, redirect handling with
// discard of in-flight words, and a stall buffer feeding the IF/ID register.
//
// state | meaning
// REQ   | request driven on the memory port at address pc
// WAIT  | one request accepted, waiting for read data
// HOLD  | returned word parked in the buffer while decode is stalled
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc_in,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] if_instr
);

    fetch_state_e state;
    logic         discard;

    logic accept_word;
    logic deliver_live;
    logic deliver_buf;
    logic capture_word;

    always_comb begin
        accept_word  = (state == ST_WAIT) && imem_rvalid && !discard && !redirect;
        deliver_live = accept_word && !stall;
        capture_word = accept_word && stall;
        deliver_buf  = (state == ST_HOLD) && !stall && !redirect;
    end

    assign imem_req  = (state == ST_REQ);
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_REQ;
            pc      <= RESET_PC;
            discard <= 1'b0;
        end else if (redirect) begin
            pc <= pc_align(next_pc_in);
            case (state)
                ST_REQ: begin
                    // An accepted request now targets the old path; drop its data.
                    if (imem_ready) begin
                        state   <= ST_WAIT;
                        discard <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state   <= ST_REQ;
                        discard <= 1'b0;
                    end else begin
                        discard <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_REQ;
                    discard <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_ready) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= ST_REQ;
                        end else if (stall) begin
                            state <= ST_HOLD;
                        end else begin
                            pc    <= pc_next_seq(pc);
                            state <= ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        pc    <= pc_next_seq(pc);
                        state <= ST_REQ;
                    end
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end

    fetch_buffer u_fetch_buffer (
        .clk         (clk),
        .reset       (reset),
        .load        (deliver_live || deliver_buf),
        .use_buf     (deliver_buf),
        .capture     (capture_word),
        .flush       (redirect),
        .hold        (stall),
        .fill_pc     (pc),
        .fill_instr  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_instr    (if_instr)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a transaction-level fetch model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_pc_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc_in;
    logic        redirect;
    logic        stall;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    int total = 0;
    int bad   = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .next_pc_in  (next_pc_in),
        .redirect    (redirect),
        .stall       (stall),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4),
        .if_instr    (if_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one outstanding request (maybe stale), a queue of
    // parked words, and the IF/ID contents.
    logic        m_started = 1'b0;
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_stale;
    logic [31:0] m_buf[$];
    logic        m_valid;
    logic [31:0] m_ifpc;
    logic [31:0] m_instr;
    logic        m_req_now;

    always @(posedge clk) begin
        m_req_now = !m_out && (m_buf.size() == 0);
        if (reset) begin
            m_started = 1'b1;
            m_pc      = 32'h0000_0000;
            m_out     = 1'b0;
            m_stale   = 1'b0;
            m_buf.delete();
            m_valid   = 1'b0;
            m_ifpc    = 32'h0000_0000;
            m_instr   = 32'h0000_0000;
        end else if (m_started) begin
            if (redirect) begin
                m_pc    = {next_pc_in[31:2], 2'b00};
                m_valid = 1'b0;
                m_buf.delete();
                if (m_out) begin
                    if (imem_rvalid) begin
                        m_out   = 1'b0;
                        m_stale = 1'b0;
                    end else begin
                        m_stale = 1'b1;
                    end
                end else if (m_req_now && imem_ready) begin
                    m_out   = 1'b1;
                    m_stale = 1'b1;
                end
            end else if (m_buf.size() != 0) begin
                if (!stall) begin
                    m_valid = 1'b1;
                    m_ifpc  = m_pc;
                    m_instr = m_buf.pop_front();
                    m_pc    = m_pc + 32'd4;
                end
            end else if (m_out && imem_rvalid) begin
                m_out = 1'b0;
                if (m_stale) begin
                    m_stale = 1'b0;
                    if (!stall) m_valid = 1'b0;
                end else if (stall) begin
                    m_buf.push_back(imem_rdata);
                end else begin
                    m_valid = 1'b1;
                    m_ifpc  = m_pc;
                    m_instr = imem_rdata;
                    m_pc    = m_pc + 32'd4;
                end
            end else begin
                if (m_req_now && imem_ready) m_out = 1'b1;
                if (!stall) m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("model_pc", pc, m_pc);
            chk("model_imem_addr", imem_addr, m_pc);
            chk("model_imem_req", 32'(imem_req), 32'(!m_out && (m_buf.size() == 0)));
            chk("model_if_valid", 32'(if_valid), 32'(m_valid));
            if (m_valid) begin
                chk("model_if_pc", if_pc, m_ifpc);
                chk("model_if_pc_plus4", if_pc_plus4, m_ifpc + 32'd4);
                chk("model_if_instr", if_instr, m_instr);
            end
        end
    end

    task automatic cyc(input logic rd, input logic [31:0] npc, input logic st,
                       input logic rdy, input logic rv, input logic [31:0] rdat);
        redirect    = rd;
        next_pc_in  = npc;
        stall       = st;
        imem_ready  = rdy;
        imem_rvalid = rv;
        imem_rdata  = rdat;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse;
        logic [31:0] words [3];
        words[0] = 32'h1111_0001;
        words[1] = 32'h2222_0002;
        words[2] = 32'h3333_0003;

        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_imem_addr", imem_addr, 32'h0000_0000);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);

        // first fetch
        cyc(0, 0, 0, 1, 0, 0);
        chk("first_wait_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0, 1, 1, 32'h2008_0005);
        chk("first_if_valid", 32'(if_valid), 32'd1);
        chk("first_if_pc", if_pc, 32'd0);
        chk("first_if_pc_plus4", if_pc_plus4, 32'd4);
        chk("first_if_instr", if_instr, 32'h2008_0005);
        chk("first_next_addr", imem_addr, 32'd4);

        // zero-wait throughput: three words in six cycles
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 0, 0);
            if (if_valid) npulse++;
            cyc(0, 0, 0, 1, 1, words[i]);
            if (if_valid) npulse++;
        end
        chk("tput_pulses", 32'(npulse), 32'd3);
        chk("tput_pc", pc, 32'h0000_0010);
        chk("tput_last_instr", if_instr, 32'h3333_0003);

        // stall while a word returns
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h0000_0044);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 32'h0000_0055);
        cyc(0, 0, 1, 0, 0, 0);
        chk("hold_req", 32'(imem_req), 32'd0);
        chk("hold_if_valid", 32'(if_valid), 32'd1);
        chk("hold_if_pc", if_pc, 32'h0000_0010);
        chk("hold_if_instr", if_instr, 32'h0000_0044);
        chk("hold_pc", pc, 32'h0000_0014);
        cyc(0, 0, 0, 0, 0, 0);
        chk("unhold_if_pc", if_pc, 32'h0000_0014);
        chk("unhold_if_instr", if_instr, 32'h0000_0055);
        chk("unhold_pc", pc, 32'h0000_0018);

        // redirect while waiting, word arrives later and is dropped
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 32'h0000_0043, 0, 0, 0, 0);
        chk("redir_wait_pc", pc, 32'h0000_0040);
        chk("redir_wait_if_valid", 32'(if_valid), 32'd0);
        cyc(0, 0, 0, 0, 1, 32'h0000_DEAD);
        chk("redir_drop_req", 32'(imem_req), 32'd1);
        chk("redir_drop_addr", imem_addr, 32'h0000_0040);
        chk("redir_drop_if_valid", 32'(if_valid), 32'd0);

        // redirect together with stall in HOLD
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1, 32'h0000_0066);
        chk("hold2_req", 32'(imem_req), 32'd0);
        cyc(1, 32'h0000_0080, 1, 0, 0, 0);
        chk("hold_redir_req", 32'(imem_req), 32'd1);
        chk("hold_redir_addr", imem_addr, 32'h0000_0080);
        chk("hold_redir_if_valid", 32'(if_valid), 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0077);
        chk("after_hold_instr", if_instr, 32'h0000_0077);
        chk("after_hold_if_pc", if_pc, 32'h0000_0080);

        // redirect in REQ without and with acceptance
        cyc(1, 32'h0000_0101, 0, 0, 0, 0);
        chk("redir_req_addr", imem_addr, 32'h0000_0100);
        chk("redir_req_req", 32'(imem_req), 32'd1);
        cyc(1, 32'h0000_0200, 0, 1, 0, 0);
        chk("redir_acc_req", 32'(imem_req), 32'd0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0099);
        chk("redir_acc_addr", imem_addr, 32'h0000_0200);
        chk("redir_acc_if_valid", 32'(if_valid), 32'd0);

        // redirect in WAIT coinciding with returning data
        cyc(0, 0, 0, 1, 0, 0);
        cyc(1, 32'h0000_0300, 0, 0, 1, 32'h0000_0098);
        chk("redir_rv_req", 32'(imem_req), 32'd1);
        chk("redir_rv_addr", imem_addr, 32'h0000_0300);
        chk("redir_rv_if_valid", 32'(if_valid), 32'd0);

        // pc wrap
        cyc(1, 32'hFFFF_FFFE, 0, 0, 0, 0);
        chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_0ABC);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_pc_plus4", if_pc_plus4, 32'h0000_0000);

        // reset in WAIT, stale data the following cycle
        cyc(0, 0, 0, 1, 0, 0);
        chk("pre_reset_req", 32'(imem_req), 32'd0);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 1, 32'h0000_0BAD);
        chk("post_reset_addr", imem_addr, 32'h0000_0000);
        chk("post_reset_req", 32'(imem_req), 32'd1);
        chk("post_reset_if_valid", 32'(if_valid), 32'd0);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h0000_1234);
        chk("post_reset_fetch_instr", if_instr, 32'h0000_1234);
        chk("post_reset_fetch_pc", if_pc, 32'h0000_0000);

        cyc(0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
